// File: rtl/cpu_pkg.sv
// Shared types and default sizes for the cpu_6502 fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   CPU_ADDR_W / CPU_DATA_W / CPU_QDEPTH / CPU_RESET_PC : default sizes
//   fetch_pkt_t : {pc, data} packet at the default widths
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_QDEPTH = 4;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] data;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO with push, pop and a flush that empties it in one edge.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller must not push into a full queue without a pop.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : empty the queue; overrides push and pop
//   push, push_dat      : write push_dat at the tail
//   pop                 : advance the head (caller gates with head_vld)
//   head_vld, head_dat  : head entry, head_dat forced to zero while empty
//   count               : number of stored entries, 0..DEPTH
module fetch_queue #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  // Push while full with a pop overwrites the slot being popped, which is safe.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= push_dat;
  end

  assign head_vld = (count != '0);
  assign head_dat = head_vld ? slots[rd_ptr] : '0;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction prefetch front end sharing one memory port with execute-stage loads/stores.
// Latency: fetch issue to head valid is one edge; load/store issue to ls_ack is one edge.
// Backpressure: out_ready low lets the queue fill, then fetch issue stops; ls_req waits for ls_ack.
//
// Ports:
//   clk, rst_n                               : clock, synchronous active-low reset
//   mem_addr, mem_rw_n, mem_wdata, mem_rdata : registered memory port, data returns one edge later
//   ls_req, ls_we, ls_addr, ls_wdata         : load/store request, held until ls_ack
//   ls_ack, ls_rdata                         : one-cycle completion pulse with load data
//   redirect_valid, redirect_pc              : taken jump/branch, flushes and restarts fetch
//   out_valid, out_ready, out_byte, out_pc   : {pc, byte} stream to decode
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter int                QDEPTH   = CPU_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw_n,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_byte,
  output logic [ADDR_W-1:0] out_pc
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic [ADDR_W-1:0]        fetch_pc;
  logic                     epoch;
  logic                     fetch_inflight;
  logic [ADDR_W-1:0]        tag_pc;
  logic                     tag_epoch;
  logic                     ls_pending;
  logic [$clog2(QDEPTH):0]  q_count;

  logic                     ls_issue;
  logic                     fetch_room;
  logic                     fetch_issue;
  logic [ADDR_W-1:0]        pc_base;
  logic                     q_push;
  logic                     q_pop;
  pkt_t                     push_pkt;
  pkt_t                     head_pkt;

  // Load/store owns the port unless one is already awaiting its ack.
  assign ls_issue = ls_req && !ls_pending && !ls_ack;

  // Counting the in-flight fetch reserves its slot, so a return always has room.
  // A redirect empties the queue and discards the return, so room is guaranteed.
  assign fetch_room  = (int'(q_count) + int'(fetch_inflight)) < QDEPTH;
  assign fetch_issue = !ls_issue && (redirect_valid || fetch_room);

  // A redirect fetches from its target in the same edge.
  assign pc_base = redirect_valid ? redirect_pc : fetch_pc;

  assign q_push   = fetch_inflight && (tag_epoch == epoch) && !redirect_valid;
  assign q_pop    = out_valid && out_ready && !redirect_valid;
  assign push_pkt = '{pc: tag_pc, data: mem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      mem_rw_n       <= 1'b1;
      mem_wdata      <= '0;
      ls_ack         <= 1'b0;
      ls_rdata       <= '0;
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      fetch_inflight <= 1'b0;
      tag_pc         <= '0;
      tag_epoch      <= 1'b0;
      ls_pending     <= 1'b0;
    end else begin
      ls_ack         <= ls_pending;
      ls_pending     <= ls_issue;
      fetch_inflight <= fetch_issue;
      if (ls_pending) ls_rdata <= mem_rdata;
      if (redirect_valid) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_pc;
      end

      if (ls_issue) begin
        mem_addr  <= ls_addr;
        mem_rw_n  <= ~ls_we;
        mem_wdata <= ls_wdata;
      end else if (fetch_issue) begin
        mem_addr  <= pc_base;
        mem_rw_n  <= 1'b1;
        tag_pc    <= pc_base;
        // Tag with the epoch that will be current when the data returns.
        tag_epoch <= epoch ^ redirect_valid;
        fetch_pc  <= pc_base + 1'b1;
      end else begin
        mem_rw_n  <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .W     ($bits(pkt_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_dat (push_pkt),
    .pop      (q_pop),
    .head_vld (out_valid),
    .head_dat (head_pkt),
    .count    (q_count)
  );

  assign out_pc   = head_pkt.pc;
  assign out_byte = head_pkt.data;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios then randomized traffic against a stream model.
// Latency: n/a.
// Backpressure: out_ready driven randomly in the random phase.
module tb_cpu_fetch_unit;
  import cpu_pkg::*;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rw_n;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [7:0]  ls_wdata;
  logic        ls_ack;
  logic [7:0]  ls_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [15:0] out_pc;

  always #5 clk = ~clk;

  cpu_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_rw_n       (mem_rw_n),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_ack         (ls_ack),
    .ls_rdata       (ls_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_pc         (out_pc)
  );

  // Synchronous memory: address registered at one edge, data used / written at the next.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (rst_n && !mem_rw_n) mem[mem_addr] <= mem_wdata;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          npkt  = 0;
  logic [15:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream model: decode sees consecutive PCs from the last redirect target, each with
  // the memory byte at that PC. A handshake in a redirect cycle is not a consumption.
  task automatic tick();
    fetch_pkt_t e;
    if (rst_n && redirect_valid) begin
      exp_pc = redirect_pc;
    end else if (rst_n && out_valid && out_ready) begin
      e.pc   = exp_pc;
      e.data = ref_mem[exp_pc];
      check("pkt_pc", 32'(out_pc), 32'(e.pc));
      check("pkt_byte", 32'(out_byte), 32'(e.data));
      exp_pc = exp_pc + 16'd1;
      npkt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({pfx, "_mem_rw_n"},  32'(mem_rw_n),  32'h1);
    check({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({pfx, "_ls_ack"},    32'(ls_ack),    32'h0);
    check({pfx, "_ls_rdata"},  32'(ls_rdata),  32'h0);
    check({pfx, "_out_valid"}, 32'(out_valid), 32'h0);
    check({pfx, "_out_byte"},  32'(out_byte),  32'h0);
    check({pfx, "_out_pc"},    32'(out_pc),    32'h0);
  endtask

  logic [15:0] p;
  logic [15:0] stall_addr;
  logic [15:0] la;
  logic [7:0]  ls_exp;
  logic        ls_busy;
  int          ls_start;
  int          last_redir;
  int          n0;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'((i * 37) + ((i >> 8) * 11) + 5);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'hA9; mem[1] = 8'h01; mem[2] = 8'h8D; mem[16'h0200] = 8'h55;
    ref_mem[0] = 8'hA9; ref_mem[1] = 8'h01; ref_mem[2] = 8'h8D; ref_mem[16'h0200] = 8'h55;

    rst_n = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_pc = 16'h0000;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Reset release: first head two edges later, then one byte per cycle.
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check("t1_valid_e0", 32'(out_valid), 32'h0);
    tick();
    check("t1_valid_e1", 32'(out_valid), 32'h1);
    check("t1_pc0", 32'(out_pc), 32'h0);
    check("t1_byte0", 32'(out_byte), 32'hA9);
    tick();
    check("t1_valid_e2", 32'(out_valid), 32'h1);
    check("t1_pc1", 32'(out_pc), 32'h1);
    check("t1_byte1", 32'(out_byte), 32'h01);
    tick();
    check("t1_valid_e3", 32'(out_valid), 32'h1);
    check("t1_pc2", 32'(out_pc), 32'h2);
    check("t1_byte2", 32'(out_byte), 32'h8D);

    // Decode stall: queue fills to QD entries and fetch stops.
    out_ready = 1'b0;
    stall_addr = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_rw_n", 32'(mem_rw_n), 32'h1);
      if (i == 5) stall_addr = mem_addr;
    end
    check("t2_addr_frozen", 32'(mem_addr), 32'(stall_addr));
    check("t2_addr_depth", 32'(mem_addr), 32'(exp_pc + 16'(QD - 1)));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_no_gap", 32'(out_valid), 32'h1);
      tick();
    end

    // Redirect while the fetch of 0x0005 is in flight.
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 20 && mem_addr != 16'h0005; k++) tick();
    check("t3_reach5", 32'(mem_addr), 32'h5);
    redirect_valid = 1'b1; redirect_pc = 16'h8000;
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(out_valid), 32'h0);
    tick();
    check("t3_valid", 32'(out_valid), 32'h1);
    check("t3_pc8000", 32'(out_pc), 32'h8000);
    tick();
    check("t3_pc8001", 32'(out_pc), 32'h8001);
    tick(); tick();

    // Load during streaming.
    p = mem_addr;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0200;
    tick();
    check("t4_addr", 32'(mem_addr), 32'h0200);
    check("t4_rw_n", 32'(mem_rw_n), 32'h1);
    check("t4_ack_early", 32'(ls_ack), 32'h0);
    tick();
    check("t4_ack", 32'(ls_ack), 32'h1);
    check("t4_rdata", 32'(ls_rdata), 32'h55);
    check("t4_fetch_resume", 32'(mem_addr), 32'(p + 16'd1));
    ls_req = 1'b0;
    tick();
    check("t4_ack_pulse", 32'(ls_ack), 32'h0);
    tick(); tick();

    // Store and redirect in the same cycle: store wins the port, redirect still applies.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0300; ls_wdata = 8'h7E;
    ref_mem[16'h0300] = 8'h7E;
    redirect_valid = 1'b1; redirect_pc = 16'h1000;
    tick();
    redirect_valid = 1'b0;
    check("t5_rw_n", 32'(mem_rw_n), 32'h0);
    check("t5_addr", 32'(mem_addr), 32'h0300);
    check("t5_wdata", 32'(mem_wdata), 32'h7E);
    check("t5_flushed", 32'(out_valid), 32'h0);
    tick();
    check("t5_ack", 32'(ls_ack), 32'h1);
    check("t5_fetch_rw_n", 32'(mem_rw_n), 32'h1);
    check("t5_fetch_addr", 32'(mem_addr), 32'h1000);
    check("t5_still_empty", 32'(out_valid), 32'h0);
    ls_req = 1'b0; ls_we = 1'b0;
    tick();
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_pc1000", 32'(out_pc), 32'h1000);
    ls_req = 1'b1; ls_addr = 16'h0300;
    tick(); tick();
    check("t5_rb_ack", 32'(ls_ack), 32'h1);
    check("t5_rb_data", 32'(ls_rdata), 32'h7E);
    ls_req = 1'b0;
    tick();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t6_pcFFFE", 32'(out_pc), 32'hFFFE);
    tick();
    check("t6_pcFFFF", 32'(out_pc), 32'hFFFF);
    tick();
    check("t6_pc0000", 32'(out_pc), 32'h0000);
    check("t6_byte0000", 32'(out_byte), 32'hA9);

    // Reset while a load is outstanding: no ack, outputs back to reset values.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0200;
    tick();
    rst_n = 1'b0; exp_pc = 16'h0000;
    tick();
    check_reset_outputs("t7");
    ls_req = 1'b0;
    tick();
    check("t7_no_ack", 32'(ls_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t7_restart_pc", 32'(out_pc), 32'h0);

    // Randomized traffic: backpressure, redirects and loads/stores to a small data window.
    n0 = npkt; last_redir = cyc; ls_busy = 1'b0; ls_start = 0; ls_exp = '0;
    for (int i = 0; i < 3000; i++) begin
      check("r_ls_ack", 32'(ls_ack), 32'(ls_busy && (cyc == ls_start + 2)));
      if (ls_busy && ls_ack) begin
        if (!ls_we) check("r_ls_rdata", 32'(ls_rdata), 32'(ls_exp));
        ls_req = 1'b0; ls_busy = 1'b0;
      end else if (ls_busy && cyc > ls_start + 2) begin
        ls_req = 1'b0; ls_busy = 1'b0;
      end else if (!ls_busy && $urandom_range(0, 9) == 0) begin
        la       = 16'hF000 + 16'($urandom_range(0, 15));
        ls_we    = 1'($urandom_range(0, 1));
        ls_wdata = 8'($urandom);
        ls_addr  = la;
        if (ls_we) ref_mem[la] = ls_wdata;
        else       ls_exp = ref_mem[la];
        ls_req = 1'b1; ls_busy = 1'b1; ls_start = cyc;
      end
      redirect_valid = ($urandom_range(0, 29) == 0) || (cyc - last_redir > 50);
      if (redirect_valid) begin
        redirect_pc = 16'h1000 + 16'($urandom_range(0, 16'h6FFF));
        last_redir  = cyc;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    redirect_valid = 1'b0; ls_req = 1'b0;
    tick(); tick();
    check("r_progress", 32'((npkt - n0) >= 1000), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
